// File: rtl/board_rst_seq_pkg.sv
// rtl/board_rst_seq_pkg.sv - state encodings, default timing and helpers for the board reset sequencer
package board_rst_seq_pkg;

    // Sequencer states; 3-bit encoding, five states
    typedef enum logic [2:0] {
        ST_PLL_RST    = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_HOLD       = 3'd2,
        ST_REL_PERIPH = 3'd3,
        ST_RUN        = 3'd4
    } rst_state_e;

    // Default timing for a 100 MHz board oscillator
    localparam int DEF_SYNC_STAGES      = 2;
    localparam int DEF_DEBOUNCE_CYC     = 1000000;
    localparam int DEF_PLL_RST_CYC      = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 65536;
    localparam int DEF_HOLD_CYC         = 256;

    // lock_retries saturates here rather than wrapping back to zero
    localparam logic [3:0] RETRY_MAX = 4'hF;

    // Largest of three counts, floored at 2 so derived counter widths never collapse to 0
    function automatic int max3_floor2(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 2 : m;
    endfunction

endpackage

// File: rtl/board_rst_seq_rst_debounce.sv
// rtl/board_rst_seq_rst_debounce.sv - synchroniser plus stability counter for one async pad
module rst_debounce
    import board_rst_seq_pkg::*;
#(
    parameter int   SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int   DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter logic INIT         = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(max3_floor2(DEBOUNCE_CYC, 2, 2));

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign dout   = db_q;

    // Shift the pad through the synchroniser; the debounced level only follows after
    // DEBOUNCE_CYC consecutive cycles of disagreement, any agreement restarts the count
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d  = cnt_q;
        db_d   = db_q;
        if (sync_s == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
            db_d  = sync_s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset parks the pad at its inactive level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{INIT}};
            cnt_q  <= '0;
            db_q   <= INIT;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

endmodule

// File: rtl/board_rst_seq.sv
// rtl/board_rst_seq.sv - board reset / MMCM bring-up sequencer with staged reset release
module board_rst_seq
    import board_rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int HOLD_CYC         = DEF_HOLD_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_rst_n,
    input  logic       pll_locked,
    input  logic       wakeup_n,
    output logic       pll_rst,
    output logic       periph_rst,
    output logic       soc_erst_n,
    output logic       sys_ready,
    output logic [3:0] lock_retries,
    output logic       wakeup_db_n,
    output logic       wake_pulse
);

    localparam int CNT_W = $clog2(max3_floor2(PLL_RST_CYC, LOCK_TIMEOUT_CYC, HOLD_CYC));

    rst_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             retries_q, retries_d;
    logic [SYNC_STAGES-1:0] locked_sync_q, locked_sync_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   periph_rst_q, periph_rst_d;
    logic                   soc_erst_n_q, soc_erst_n_d;
    logic                   sys_ready_q, sys_ready_d;
    logic                   wake_prev_q, wake_prev_d;
    logic                   wake_pulse_q, wake_pulse_d;
    logic                   btn_db;
    logic                   wake_db;
    logic                   locked_s;

    // Reset button: low means pressed, so it idles high
    rst_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .INIT         (1'b1)
    ) u_btn_db (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn_rst_n),
        .dout  (btn_db)
    );

    // Wake pad: low means wake, so it idles high
    rst_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .INIT         (1'b1)
    ) u_wake_db (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (wakeup_n),
        .dout  (wake_db)
    );

    // MMCM lock is only synchronised: its loss must act fast, not be filtered
    assign locked_s      = locked_sync_q[SYNC_STAGES-1];
    assign locked_sync_d = {locked_sync_q[SYNC_STAGES-2:0], pll_locked};

    // Next state: button beats everything, lock loss beats normal progress after lock
    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        cnt_d     = cnt_q + CNT_W'(1);
        if (!btn_db) begin
            state_d = ST_PLL_RST;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == CNT_W'(PLL_RST_CYC - 1)) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_HOLD;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
                        state_d   = ST_PLL_RST;
                        retries_d = (retries_q == RETRY_MAX) ? RETRY_MAX : retries_q + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (!locked_s) state_d = ST_PLL_RST;
                    else if (cnt_q == CNT_W'(HOLD_CYC - 1)) state_d = ST_REL_PERIPH;
                end
                ST_REL_PERIPH: begin
                    if (!locked_s) state_d = ST_PLL_RST;
                    else if (cnt_q == CNT_W'(HOLD_CYC - 1)) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!locked_s) state_d = ST_PLL_RST;
                end
                default: state_d = ST_PLL_RST;
            endcase
        end
        // Counter restarts on every state change; it is pinned at zero while the
        // button is held and in RUN, where nothing is being timed
        if ((state_d != state_q) || !btn_db || (state_d == ST_RUN)) begin
            cnt_d = '0;
        end
    end

    // Output decode from the next state so every output comes straight off a flop
    always_comb begin
        pll_rst_d    = (state_d == ST_PLL_RST);
        periph_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_WAIT_LOCK) ||
                       (state_d == ST_HOLD);
        soc_erst_n_d = (state_d == ST_RUN);
        sys_ready_d  = (state_d == ST_RUN);
        wake_prev_d  = wake_db;
        wake_pulse_d = wake_prev_q & ~wake_db;
    end

    // Sequencer and output registers; reset holds everything in reset immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_PLL_RST;
            cnt_q         <= '0;
            retries_q     <= '0;
            locked_sync_q <= '0;
            pll_rst_q     <= 1'b1;
            periph_rst_q  <= 1'b1;
            soc_erst_n_q  <= 1'b0;
            sys_ready_q   <= 1'b0;
            wake_prev_q   <= 1'b1;
            wake_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retries_q     <= retries_d;
            locked_sync_q <= locked_sync_d;
            pll_rst_q     <= pll_rst_d;
            periph_rst_q  <= periph_rst_d;
            soc_erst_n_q  <= soc_erst_n_d;
            sys_ready_q   <= sys_ready_d;
            wake_prev_q   <= wake_prev_d;
            wake_pulse_q  <= wake_pulse_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign periph_rst   = periph_rst_q;
    assign soc_erst_n   = soc_erst_n_q;
    assign sys_ready    = sys_ready_q;
    assign lock_retries = retries_q;
    assign wakeup_db_n  = wake_db;
    assign wake_pulse   = wake_pulse_q;

endmodule

// File: tb/tb_board_rst_seq.sv
// tb/tb_board_rst_seq.sv - scoreboard bench for board_rst_seq with directed timing vectors
module tb_board_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_rst_n;
    logic       pll_locked;
    logic       wakeup_n;
    logic       pll_rst;
    logic       periph_rst;
    logic       soc_erst_n;
    logic       sys_ready;
    logic [3:0] lock_retries;
    logic       wakeup_db_n;
    logic       wake_pulse;

    board_rst_seq #(
        .SYNC_STAGES      (2),
        .DEBOUNCE_CYC     (8),
        .PLL_RST_CYC      (4),
        .LOCK_TIMEOUT_CYC (32),
        .HOLD_CYC         (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_rst_n    (btn_rst_n),
        .pll_locked   (pll_locked),
        .wakeup_n     (wakeup_n),
        .pll_rst      (pll_rst),
        .periph_rst   (periph_rst),
        .soc_erst_n   (soc_erst_n),
        .sys_ready    (sys_ready),
        .lock_retries (lock_retries),
        .wakeup_db_n  (wakeup_db_n),
        .wake_pulse   (wake_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [9:0] vec;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic       mon_en = 1'b0;
    logic [9:0] last_vec;
    logic [9:0] outv;

    // {pll_rst, periph_rst, soc_erst_n, sys_ready, lock_retries, wakeup_db_n, wake_pulse}
    localparam logic [9:0] RESET_VEC = 10'b1100_0000_10;

    assign outv = {pll_rst, periph_rst, soc_erst_n, sys_ready, lock_retries, wakeup_db_n, wake_pulse};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] mk(input logic p, input logic r, input logic s,
                                      input logic y, input logic [3:0] n,
                                      input logic db, input logic wp);
        return {p, r, s, y, n, db, wp};
    endfunction

    task automatic push(input int c, input logic [9:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic at(input int n);
        while (cyc != n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_now(input string name, input logic [9:0] exp_v);
        n_cmp++;
        if (outv !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, outv, exp_v);
        end
    endtask

    // Monitor: every change of the output vector must match the next expected event, cycle included
    always @(negedge clk) begin
        if (mon_en && (outv !== last_vec)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_change: got %b at cyc %0d, expected no change", outv, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if ((e.cyc != cyc) || (e.vec !== outv)) begin
                    n_err++;
                    $display("FAIL out_event: got %b at cyc %0d, expected %b at cyc %0d",
                             outv, cyc, e.vec, e.cyc);
                end
            end
            last_vec = outv;
        end
    end

    initial begin
        rst_n      = 1'b0;
        btn_rst_n  = 1'b1;
        pll_locked = 1'b0;
        wakeup_n   = 1'b1;

        at(3);
        chk_now("reset_values", RESET_VEC);
        last_vec = RESET_VEC;
        rst_n    = 1'b1;
        mon_en   = 1'b1;

        // Bring-up: lock arrives 20 cycles after release
        push(7,  mk(0, 1, 0, 0, 4'd0, 1, 0));
        push(34, mk(0, 0, 0, 0, 4'd0, 1, 0));
        push(42, mk(0, 0, 1, 1, 4'd0, 1, 0));
        at(23);
        pll_locked = 1'b1;

        // Lock timeout: 36-cycle retry period, retries saturate at 15, then re-lock
        at(50);
        push(53, mk(1, 1, 0, 0, 4'd0, 1, 0));
        push(57, mk(0, 1, 0, 0, 4'd0, 1, 0));
        for (int n = 1; n <= 16; n++) begin
            logic [3:0] r;
            r = (n > 15) ? 4'd15 : 4'(n);
            push(53 + 36 * n, mk(1, 1, 0, 0, r, 1, 0));
            push(57 + 36 * n, mk(0, 1, 0, 0, r, 1, 0));
        end
        push(651, mk(0, 0, 0, 0, 4'd15, 1, 0));
        push(659, mk(0, 0, 1, 1, 4'd15, 1, 0));
        pll_locked = 1'b0;
        at(640);
        pll_locked = 1'b1;

        // Button bounce ignored, long press restarts the whole sequence
        at(670);
        push(711, mk(1, 1, 0, 0, 4'd15, 1, 0));
        push(734, mk(0, 1, 0, 0, 4'd15, 1, 0));
        push(743, mk(0, 0, 0, 0, 4'd15, 1, 0));
        push(751, mk(0, 0, 1, 1, 4'd15, 1, 0));
        for (int k = 0; k < 3; k++) begin
            at(670 + 10 * k);
            btn_rst_n = 1'b0;
            at(675 + 10 * k);
            btn_rst_n = 1'b1;
        end
        at(700);
        btn_rst_n = 1'b0;
        at(720);
        btn_rst_n = 1'b1;

        // One-cycle lock loss in RUN
        at(760);
        push(763, mk(1, 1, 0, 0, 4'd15, 1, 0));
        push(767, mk(0, 1, 0, 0, 4'd15, 1, 0));
        push(776, mk(0, 0, 0, 0, 4'd15, 1, 0));
        push(784, mk(0, 0, 1, 1, 4'd15, 1, 0));
        pll_locked = 1'b0;
        at(761);
        pll_locked = 1'b1;

        // Wake: 12-cycle press gives one pulse, 4-cycle glitch gives nothing
        at(790);
        push(800, mk(0, 0, 1, 1, 4'd15, 0, 0));
        push(801, mk(0, 0, 1, 1, 4'd15, 0, 1));
        push(802, mk(0, 0, 1, 1, 4'd15, 0, 0));
        push(812, mk(0, 0, 1, 1, 4'd15, 1, 0));
        wakeup_n = 1'b0;
        at(802);
        wakeup_n = 1'b1;
        at(820);
        wakeup_n = 1'b0;
        at(824);
        wakeup_n = 1'b1;

        // Async reset while in REL_PERIPH
        at(830);
        push(833, mk(1, 1, 0, 0, 4'd15, 1, 0));
        push(837, mk(0, 1, 0, 0, 4'd15, 1, 0));
        push(846, mk(0, 0, 0, 0, 4'd15, 1, 0));
        pll_locked = 1'b0;
        at(831);
        pll_locked = 1'b1;
        at(850);
        push(850, RESET_VEC);
        rst_n = 1'b0;
        #1;
        chk_now("async_reset", RESET_VEC);

        at(856);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_events: got %0d pending, expected 0 (next at cyc %0d)",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
